// File: rtl/keypad_scanner_if.sv
// Key event bundle leaving the keypad scanner.
// Carries the accepted code, its strobe, hold level and nibble history.
interface keypad_scanner_if;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] digits_out;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output digits_out
    );

    modport slave (
        input key_code,
        input key_valid,
        input key_held,
        input digits_out
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with scan-level debounce.
// Emits accepted key codes and keeps a four-nibble history.
module keypad_scanner #(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         col_in,
    output logic [3:0]         row_out,
    keypad_scanner_if.master   key_bus
);
    typedef enum logic [1:0] {
        IDLE, ACCEPT, HELD, RELEASE
    } state_t;

    typedef enum logic [1:0] {
        R_NONE, R_KEY, R_MULTI
    } kind_t;

    localparam logic [14:0] LAST = 15'(SCAN_DIV - 1);
    localparam logic [3:0]  DB   = 4'(DEBOUNCE_SCANS);

    logic [3:0]  sync1, sync2;
    logic [14:0] row_cnt;
    logic [1:0]  row_idx;
    logic        acc_found, acc_multi;
    logic [3:0]  acc_code;

    state_t      state;
    kind_t       prev_kind;
    logic [3:0]  prev_code;
    logic [3:0]  stable_cnt;
    logic [3:0]  rel_cnt;

    logic [3:0]  key_code_q;
    logic        key_valid_q;
    logic        key_held_q;
    logic [15:0] digits_q;

    logic        sample, eval;
    logic [3:0]  col_low, sel;
    logic        one_hot;
    logic [1:0]  col_idx;
    logic        nxt_found, nxt_multi;
    logic [3:0]  nxt_code;
    kind_t       res_kind;
    logic [3:0]  res_code;
    logic [3:0]  stab_nxt;
    logic [3:0]  rel_nxt;
    logic        is_held_key;

    assign row_out = ~(4'b0001 << row_idx);
    assign sample  = (row_cnt == LAST);
    assign eval    = sample && (row_idx == 2'd3);

    assign key_bus.key_code   = key_code_q;
    assign key_bus.key_valid  = key_valid_q;
    assign key_bus.key_held   = key_held_q;
    assign key_bus.digits_out = digits_q;

    always_comb begin
        col_low = ~sync2;
        one_hot = (col_low != 4'd0) &&
                  ((col_low & (col_low - 4'd1)) == 4'd0);
        sel     = one_hot ? col_low : 4'd0;
        col_idx = 2'd0;
        unique case (1'b1)
            sel[0]:  col_idx = 2'd0;
            sel[1]:  col_idx = 2'd1;
            sel[2]:  col_idx = 2'd2;
            sel[3]:  col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    // Fold the current row sample into this scan's running result.
    always_comb begin
        nxt_found = acc_found;
        nxt_multi = acc_multi;
        nxt_code  = acc_code;
        if (col_low != 4'd0) begin
            if (one_hot && !acc_found && !acc_multi) begin
                nxt_found = 1'b1;
                nxt_code  = {row_idx, col_idx};
            end else begin
                nxt_multi = 1'b1;
            end
        end
        res_kind = nxt_multi ? R_MULTI
                 : nxt_found ? R_KEY : R_NONE;
        res_code = (res_kind == R_KEY) ? nxt_code : 4'd0;
        if (res_kind == prev_kind && res_code == prev_code)
            stab_nxt = (stable_cnt == 4'd15) ? 4'd15
                     : stable_cnt + 4'd1;
        else
            stab_nxt = 4'd1;
        rel_nxt     = rel_cnt + 4'd1;
        is_held_key = (res_kind == R_KEY) &&
                      (res_code == key_code_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 4'hF;
            sync2     <= 4'hF;
            row_cnt   <= 15'd0;
            row_idx   <= 2'd0;
            acc_found <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= 4'd0;
        end else begin
            sync1 <= col_in;
            sync2 <= sync1;
            if (sample) begin
                row_cnt   <= 15'd0;
                row_idx   <= row_idx + 2'd1;
                acc_found <= eval ? 1'b0 : nxt_found;
                acc_multi <= eval ? 1'b0 : nxt_multi;
                acc_code  <= eval ? 4'd0 : nxt_code;
            end else begin
                row_cnt <= row_cnt + 15'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prev_kind   <= R_NONE;
            prev_code   <= 4'd0;
            stable_cnt  <= 4'd0;
            rel_cnt     <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            digits_q    <= 16'd0;
        end else begin
            if (state == ACCEPT) begin
                key_valid_q <= 1'b0;
                state       <= HELD;
            end
            if (eval) begin
                prev_kind  <= res_kind;
                prev_code  <= res_code;
                stable_cnt <= stab_nxt;
                case (state)
                    IDLE: begin
                        if (res_kind == R_KEY && stab_nxt >= DB) begin
                            state       <= ACCEPT;
                            key_code_q  <= res_code;
                            key_valid_q <= 1'b1;
                            key_held_q  <= 1'b1;
                            digits_q    <= {digits_q[11:0], res_code};
                        end
                    end
                    HELD: begin
                        if (!is_held_key) begin
                            if (DB <= 4'd1) begin
                                key_held_q <= 1'b0;
                                state      <= IDLE;
                                stable_cnt <= 4'd0;
                                rel_cnt    <= 4'd0;
                            end else begin
                                state   <= RELEASE;
                                rel_cnt <= 4'd1;
                            end
                        end
                    end
                    RELEASE: begin
                        if (is_held_key) begin
                            state   <= HELD;
                            rel_cnt <= 4'd0;
                        end else if (rel_nxt >= DB) begin
                            key_held_q <= 1'b0;
                            state      <= IDLE;
                            stable_cnt <= 4'd0;
                            rel_cnt    <= 4'd0;
                        end else begin
                            rel_cnt <= rel_nxt;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
